// File: rtl/ddr3_arb_pkg.sv
// Shared definitions for the two-port DDR3 command arbiter: FSM states,
// latched command modes and the post-release settle time.
package ddr3_arb_pkg;

    localparam int ADDR_W = 28;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        OWN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    typedef enum logic {
        MODE_WRITE = 1'b0,
        MODE_READ  = 1'b1
    } arb_mode_e;

    // Cycles to wait after deasserting the enables before ctrl_idle is trusted.
    localparam int unsigned DRAIN_SETTLE = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin pick. The last-owner pointer only moves when the
// top level releases a grant, so a contested pick favours the other port.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       owner,
    output logic [1:0] gnt
);

    logic last_q, last_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (update) begin
            last_d = owner;
        end
    end

    // Reset to "port 1 went last" so port 0 wins the first contested round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Shares one ddr3_controller command interface between two requester ports.
// A grant persists through a drain phase until the controller reports idle.
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int HOLD_WIDTH = 16,
    parameter int MAX_HOLD   = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_write_en,
    input  logic [ADDR_W-1:0] p0_write_address,
    input  logic              p0_read_en,
    input  logic [ADDR_W-1:0] p0_read_address,
    output logic              p0_grant,
    output logic              p0_preempt,
    input  logic              p1_write_en,
    input  logic [ADDR_W-1:0] p1_write_address,
    input  logic              p1_read_en,
    input  logic [ADDR_W-1:0] p1_read_address,
    output logic              p1_grant,
    output logic              p1_preempt,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_address,
    output logic              read_en,
    output logic [ADDR_W-1:0] read_address,
    input  logic              ctrl_idle,
    output logic              busy
);

    localparam logic [HOLD_WIDTH-1:0] HOLD_LIMIT =
        HOLD_WIDTH'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);

    arb_state_e            state_q, state_d;
    arb_mode_e             mode_q, mode_d;
    logic                  owner_q, owner_d;
    logic [HOLD_WIDTH-1:0] hold_q, hold_d;
    logic [1:0]            settle_q, settle_d;
    logic [1:0]            grant_q, grant_d;
    logic [1:0]            preempt_q, preempt_d;
    logic                  write_en_q, write_en_d;
    logic                  read_en_q, read_en_d;
    logic [ADDR_W-1:0]     write_address_q, write_address_d;
    logic [ADDR_W-1:0]     read_address_q, read_address_d;

    logic [1:0] req;
    logic [1:0] pick;
    logic       rr_update;
    logic       win_port;
    logic       win_write;
    logic       owner_live;
    logic       other_req;
    logic       hold_hit;

    assign req       = {p1_write_en | p1_read_en, p0_write_en | p0_read_en};
    assign win_port  = pick[1];
    assign win_write = win_port ? p1_write_en : p0_write_en;

    // Only the latched-mode enable keeps the grant alive; the other is ignored.
    assign owner_live = (mode_q == MODE_WRITE)
                      ? (owner_q ? p1_write_en : p0_write_en)
                      : (owner_q ? p1_read_en  : p0_read_en);
    assign other_req  = owner_q ? req[0] : req[1];
    assign hold_hit   = (MAX_HOLD != 0) && (hold_q == HOLD_LIMIT);

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .update (rr_update),
        .owner  (owner_q),
        .gnt    (pick)
    );

    // NOTE: every signal assigned here gets a default first, otherwise
    // paths that skip an assignment would infer latches.
    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        owner_d         = owner_q;
        hold_d          = hold_q;
        settle_d        = settle_q;
        grant_d         = grant_q;
        preempt_d       = 2'b00;
        write_en_d      = write_en_q;
        read_en_d       = read_en_q;
        write_address_d = write_address_q;
        read_address_d  = read_address_q;
        rr_update       = 1'b0;

        case (state_q)
            ARB: begin
                if (|pick) begin
                    state_d = OWN;
                    owner_d = win_port;
                    grant_d = pick;
                    if (win_write) begin
                        mode_d          = MODE_WRITE;
                        write_en_d      = 1'b1;
                        write_address_d = win_port ? p1_write_address : p0_write_address;
                    end else begin
                        mode_d         = MODE_READ;
                        read_en_d      = 1'b1;
                        read_address_d = win_port ? p1_read_address : p0_read_address;
                    end
                end
            end
            OWN: begin
                if (!owner_live || (hold_hit && other_req)) begin
                    state_d    = DRAIN;
                    settle_d   = 2'd0;
                    write_en_d = 1'b0;
                    read_en_d  = 1'b0;
                    // A simultaneous drop wins over preemption: no pulse.
                    if (owner_live) begin
                        preempt_d = owner_q ? 2'b10 : 2'b01;
                    end
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            DRAIN: begin
                if (settle_q != 2'(DRAIN_SETTLE)) begin
                    settle_d = settle_q + 2'd1;
                end else if (ctrl_idle) begin
                    state_d   = ARB;
                    grant_d   = 2'b00;
                    hold_d    = '0;
                    rr_update = 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its peers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ARB;
            mode_q          <= MODE_WRITE;
            owner_q         <= 1'b0;
            hold_q          <= '0;
            settle_q        <= 2'd0;
            grant_q         <= 2'b00;
            preempt_q       <= 2'b00;
            write_en_q      <= 1'b0;
            read_en_q       <= 1'b0;
            write_address_q <= '0;
            read_address_q  <= '0;
        end else begin
            state_q         <= state_d;
            mode_q          <= mode_d;
            owner_q         <= owner_d;
            hold_q          <= hold_d;
            settle_q        <= settle_d;
            grant_q         <= grant_d;
            preempt_q       <= preempt_d;
            write_en_q      <= write_en_d;
            read_en_q       <= read_en_d;
            write_address_q <= write_address_d;
            read_address_q  <= read_address_d;
        end
    end

    assign p0_grant      = grant_q[0];
    assign p1_grant      = grant_q[1];
    assign p0_preempt    = preempt_q[0];
    assign p1_preempt    = preempt_q[1];
    assign write_en      = write_en_q;
    assign read_en       = read_en_q;
    assign write_address = write_address_q;
    assign read_address  = read_address_q;
    assign busy          = (state_q != ARB);

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Self-checking bench for ddr3_port_arbiter: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_ddr3_port_arbiter;

    localparam int MAX_HOLD = 8;

    logic        clk;
    logic        rst;
    logic        p0_write_en, p0_read_en, p1_write_en, p1_read_en;
    logic [27:0] p0_write_address, p0_read_address;
    logic [27:0] p1_write_address, p1_read_address;
    logic        p0_grant, p0_preempt, p1_grant, p1_preempt;
    logic        write_en, read_en, ctrl_idle, busy;
    logic [27:0] write_address, read_address;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: owner -1 means nobody holds the controller.
    int          m_owner;
    bit          m_drain;
    bit          m_write;
    int          m_held;
    int          m_age;
    int          m_last;
    bit          exp_pre0, exp_pre1;
    logic [27:0] exp_waddr, exp_raddr;

    ddr3_port_arbiter #(.HOLD_WIDTH(16), .MAX_HOLD(MAX_HOLD)) dut (
        .clk              (clk),
        .rst              (rst),
        .p0_write_en      (p0_write_en),
        .p0_write_address (p0_write_address),
        .p0_read_en       (p0_read_en),
        .p0_read_address  (p0_read_address),
        .p0_grant         (p0_grant),
        .p0_preempt       (p0_preempt),
        .p1_write_en      (p1_write_en),
        .p1_write_address (p1_write_address),
        .p1_read_en       (p1_read_en),
        .p1_read_address  (p1_read_address),
        .p1_grant         (p1_grant),
        .p1_preempt       (p1_preempt),
        .write_en         (write_en),
        .write_address    (write_address),
        .read_en          (read_en),
        .read_address     (read_address),
        .ctrl_idle        (ctrl_idle),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_drain   = 0;
        m_write   = 0;
        m_held    = 0;
        m_age     = 0;
        m_last    = 1;
        exp_pre0  = 0;
        exp_pre1  = 0;
        exp_waddr = '0;
        exp_raddr = '0;
    endtask

    task automatic model_step();
        bit rq0, rq1, live, other;
        rq0 = p0_write_en | p0_read_en;
        rq1 = p1_write_en | p1_read_en;
        exp_pre0 = 0;
        exp_pre1 = 0;
        if (m_owner < 0) begin
            if (rq0 || rq1) begin
                if (rq0 && rq1) m_owner = 1 - m_last;
                else            m_owner = rq0 ? 0 : 1;
                m_write = (m_owner == 0) ? p0_write_en : p1_write_en;
                if (m_write) exp_waddr = (m_owner == 0) ? p0_write_address : p1_write_address;
                else         exp_raddr = (m_owner == 0) ? p0_read_address  : p1_read_address;
                m_held  = 0;
                m_drain = 0;
            end
        end else if (!m_drain) begin
            if (m_owner == 0) live = m_write ? p0_write_en : p0_read_en;
            else              live = m_write ? p1_write_en : p1_read_en;
            other = (m_owner == 0) ? rq1 : rq0;
            if (!live) begin
                m_drain = 1;
                m_age   = 0;
            end else if (m_held == MAX_HOLD - 1 && other) begin
                m_drain = 1;
                m_age   = 0;
                if (m_owner == 0) exp_pre0 = 1;
                else              exp_pre1 = 1;
            end else begin
                m_held++;
            end
        end else begin
            if (m_age >= 2 && ctrl_idle) begin
                m_last  = m_owner;
                m_owner = -1;
                m_drain = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic compare_all();
        bit own;
        own = (m_owner >= 0) && !m_drain;
        check("p0_grant", p0_grant, m_owner == 0);
        check("p1_grant", p1_grant, m_owner == 1);
        check("write_en", write_en, own && m_write);
        check("read_en", read_en, own && !m_write);
        check("p0_preempt", p0_preempt, exp_pre0);
        check("p1_preempt", p1_preempt, exp_pre1);
        check("busy", busy, m_owner >= 0);
        if (own && m_write)  check("write_address", write_address, exp_waddr);
        if (own && !m_write) check("read_address", read_address, exp_raddr);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_inputs();
        p0_write_en = 0; p0_read_en = 0; p1_write_en = 0; p1_read_en = 0;
        p0_write_address = '0; p0_read_address = '0;
        p1_write_address = '0; p1_read_address = '0;
        ctrl_idle = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        clear_inputs();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        check("rst_waddr", write_address, 28'h0);
        check("rst_raddr", read_address, 28'h0);
        rst = 0;
    endtask

    task automatic drain_all();
        clear_inputs();
        for (int i = 0; i < 8; i++) step();
    endtask

    initial begin
        int pre_cnt, wen_cnt, waited;
        rst = 1;
        clear_inputs();
        model_reset();

        // Single writer, clean release through the settle phase.
        do_reset();
        p0_write_en = 1; p0_write_address = 28'h0000100;
        step();
        check("s1_grant", p0_grant, 1'b1);
        check("s1_wen", write_en, 1'b1);
        check("s1_waddr", write_address, 28'h0000100);
        p0_write_en = 0;
        step();
        check("s1_wen_off", write_en, 1'b0);
        step(); step();
        check("s1_grant_settle", p0_grant, 1'b1);
        step();
        check("s1_release", p0_grant, 1'b0);

        // Contested reads straight after reset.
        do_reset();
        p0_read_en = 1; p0_read_address = 28'h0AAAAAA;
        p1_read_en = 1; p1_read_address = 28'h0555555;
        step();
        check("s2_p0_first", p0_grant, 1'b1);
        p0_read_en = 0;
        waited = 0;
        while (!p1_grant && waited < 12) begin
            step();
            waited++;
        end
        check("s2_p1_granted", p1_grant, 1'b1);
        check("s2_p1_raddr", read_address, 28'h0555555);

        // Port 1 keeps the grant while the controller stays busy.
        p1_read_en = 0; ctrl_idle = 0;
        for (int i = 0; i < 20; i++) step();
        check("s3_held", p1_grant, 1'b1);
        check("s3_no_ren", read_en, 1'b0);
        ctrl_idle = 1;
        step();
        check("s3_released", p1_grant, 1'b0);

        // Hold-limit preemption of port 0 by a waiting port 1.
        do_reset();
        p0_write_en = 1; p0_write_address = 28'h0123456;
        pre_cnt = 0; wen_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 1) begin
                p1_write_en = 1; p1_write_address = 28'h0FEDCBA;
            end
            step();
            if (p0_preempt) pre_cnt++;
            if (write_en && p0_grant) wen_cnt++;
        end
        check("s4_preempt_once", pre_cnt, 1);
        check("s4_own_cycles", wen_cnt, MAX_HOLD);
        waited = 0;
        while (!p1_grant && waited < 12) begin
            step();
            waited++;
        end
        check("s4_p1_granted", p1_grant, 1'b1);
        drain_all();

        // Write beats read; dropping the unlatched enable keeps the grant.
        do_reset();
        p0_write_en = 1; p0_read_en = 1;
        p0_write_address = 28'h0000abc; p0_read_address = 28'h0000def;
        step();
        check("s5_wen", write_en, 1'b1);
        check("s5_ren", read_en, 1'b0);
        p0_read_en = 0;
        step(); step();
        check("s5_held", p0_grant, 1'b1);

        // Asynchronous reset in the middle of a grant.
        #2 rst = 1;
        #1;
        check("s6_grant", p0_grant, 1'b0);
        check("s6_wen", write_en, 1'b0);
        check("s6_waddr", write_address, 28'h0);
        check("s6_busy", busy, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 0;
        p1_write_en = 1;
        step();
        check("s6_p0_priority", p0_grant, 1'b1);
        drain_all();

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(15) == 0) p0_write_en = ~p0_write_en;
            if ($urandom_range(15) == 0) p0_read_en  = ~p0_read_en;
            if ($urandom_range(15) == 0) p1_write_en = ~p1_write_en;
            if ($urandom_range(15) == 0) p1_read_en  = ~p1_read_en;
            p0_write_address = 28'($urandom);
            p0_read_address  = 28'($urandom);
            p1_write_address = 28'($urandom);
            p1_read_address  = 28'($urandom);
            ctrl_idle = ($urandom_range(3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
